// File: rtl/lcu_adder_pipe.sv
// lcu_adder_pipe: pipelined carry-lookahead adder/subtractor.
// The WIDTH-bit word is cut into STAGES slices of SLICE bits. Slice k is added
// in stage k using 4-bit lookahead groups; the slice carry is registered and
// feeds stage k+1. Upper operand slices ride along in skew registers and the
// finished lower sum slices are carried forward to the output stage.
module lcu_adder_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             pg,
    output logic             gg
);
    // WIDTH must be a multiple of 4*STAGES so every slice holds whole groups.
    localparam int SLICE = WIDTH / STAGES;
    localparam int NGRP  = SLICE / 4;
    localparam int LAST  = STAGES - 1;

    typedef struct packed {
        logic [SLICE-1:0] s;   // slice sum
        logic             co;  // carry out of the slice
        logic             cm;  // carry into the slice MSB
        logic             p;   // slice propagate
        logic             g;   // slice generate (carry-in independent)
    } slice_res_t;

    // One slice: bit p/g, 4-bit group P/G, then a group-level carry chain.
    function automatic slice_res_t slice_add(input logic [SLICE-1:0] xa,
                                             input logic [SLICE-1:0] xb,
                                             input logic             ci);
        logic [SLICE-1:0] p;
        logic [SLICE-1:0] g;
        logic [SLICE:0]   c;
        logic [NGRP-1:0]  gp;
        logic [NGRP-1:0]  gq;
        logic [NGRP:0]    gc;
        slice_res_t       res;
        p = xa ^ xb;
        g = xa & xb;
        for (int j = 0; j < NGRP; j++) begin
            gp[j] = &p[4*j +: 4];
            gq[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
        end
        gc[0] = ci;
        for (int j = 0; j < NGRP; j++) begin
            gc[j+1] = gq[j] | (gp[j] & gc[j]);
        end
        for (int j = 0; j < NGRP; j++) begin
            c[4*j] = gc[j];
            for (int i = 0; i < 3; i++) begin
                c[4*j+i+1] = g[4*j+i] | (p[4*j+i] & c[4*j+i]);
            end
        end
        c[SLICE] = gc[NGRP];
        res.s  = p ^ c[SLICE-1:0];
        res.co = c[SLICE];
        res.cm = c[SLICE-1];
        res.p  = &gp;
        res.g  = gq[0];
        for (int j = 1; j < NGRP; j++) begin
            res.g = gq[j] | (gp[j] & res.g);
        end
        return res;
    endfunction

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Whole pipe advances together; a held output freezes every stage.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign b_eff    = sub ? ~b : b;
    assign c0       = cin ^ sub;

    logic             vld_p  [STAGES];
    logic             cy_p   [STAGES];
    logic             cm_p   [STAGES];
    logic             pacc_p [STAGES];
    logic             gacc_p [STAGES];
    logic             zacc_p [STAGES];
    logic [SLICE-1:0] sum_p  [STAGES][STAGES];
    logic [SLICE-1:0] a_p    [STAGES][STAGES];
    logic [SLICE-1:0] b_p    [STAGES][STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam bit FIRST = (k == 0);
        localparam bit FINAL = (k == LAST);
        localparam int KP    = FIRST ? 0 : k - 1;

        logic [SLICE-1:0] xa;
        logic [SLICE-1:0] xb;
        logic             ci;
        logic             pin;
        logic             gin;
        logic             zin;
        slice_res_t       r;

        // ---- stage k: operands from the input port (k=0) or the skew of stage k-1
        assign xa  = FIRST ? a[k*SLICE +: SLICE] : a_p[KP][k];
        assign xb  = FIRST ? b_eff[k*SLICE +: SLICE] : b_p[KP][k];
        assign ci  = FIRST ? c0 : cy_p[KP];
        assign pin = FIRST ? 1'b1 : pacc_p[KP];
        assign gin = FIRST ? 1'b0 : gacc_p[KP];
        assign zin = FIRST ? 1'b1 : zacc_p[KP];
        assign r   = slice_add(xa, xb, ci);

        // Stage valid bit: shifts with the pipe, cleared by reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_p[k] <= 1'b0;
            end else if (en) begin
                vld_p[k] <= FIRST ? in_valid : vld_p[KP];
            end
        end

        // Stage data: slice result, chained carry, accumulated P/G/zero, skew.
        always_ff @(posedge clk) begin
            if (FINAL && rst) begin
                for (int j = 0; j < STAGES; j++) begin
                    sum_p[k][j] <= '0;
                end
                cy_p[k]   <= 1'b0;
                cm_p[k]   <= 1'b0;
                pacc_p[k] <= 1'b0;
                gacc_p[k] <= 1'b0;
                zacc_p[k] <= 1'b0;
            end else if (en) begin
                for (int j = 0; j < STAGES; j++) begin
                    if (j == k) begin
                        sum_p[k][j] <= r.s;
                    end else if (j < k) begin
                        sum_p[k][j] <= sum_p[KP][j];
                    end else begin
                        sum_p[k][j] <= '0;
                    end
                    a_p[k][j] <= FIRST ? a[j*SLICE +: SLICE] : a_p[KP][j];
                    b_p[k][j] <= FIRST ? b_eff[j*SLICE +: SLICE] : b_p[KP][j];
                end
                cy_p[k]   <= r.co;
                cm_p[k]   <= r.cm;
                pacc_p[k] <= pin & r.p;
                gacc_p[k] <= r.g | (r.p & gin);
                zacc_p[k] <= zin & (r.s == '0);
            end
        end
    end

    // ---- output: last stage registers drive the result ports directly
    always_comb begin
        sum = '0;
        for (int j = 0; j < STAGES; j++) begin
            sum[j*SLICE +: SLICE] = sum_p[LAST][j];
        end
    end

    assign out_valid = vld_p[LAST];
    assign cout      = cy_p[LAST];
    assign ovf       = cm_p[LAST] ^ cy_p[LAST];
    assign zero      = zacc_p[LAST];
    assign pg        = pacc_p[LAST];
    assign gg        = gacc_p[LAST];

endmodule

// File: tb/tb_lcu_adder_pipe.sv
`timescale 1ns/1ps
// Bench for lcu_adder_pipe (16 bits, 2 stages): the driver pushes the expected
// result of every accepted operation; an independent monitor pops and compares
// on each output transfer.
module tb_lcu_adder_pipe;
    localparam int W  = 16;
    localparam int ST = 2;

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         cin       = 1'b0;
    logic         sub       = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         pg;
    logic         gg;

    typedef struct {
        logic [W+4:0] v;    // {sum, cout, ovf, zero, pg, gg}
        int           acc;  // cycle in which the op was presented and taken
        bit           lat;  // check exact latency for this op
    } sb_t;

    sb_t sbq[$];
    int  checks     = 0;
    int  errors     = 0;
    int  cyc        = 0;
    bit  lat_chk    = 1'b1;
    bit  rand_ready = 1'b0;

    lcu_adder_pipe #(.WIDTH(W), .STAGES(ST)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .pg        (pg),
        .gg        (gg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer arithmetic on the operation's definition.
    function automatic logic [W+4:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                           input logic tcin, input logic tsub);
        logic [W-1:0] be;
        logic         c0;
        logic [W:0]   full;
        logic [W:0]   nocin;
        int           s;
        logic         m_ovf;
        be    = tsub ? ~tb : tb;
        c0    = tcin ^ tsub;
        full  = {1'b0, ta} + {1'b0, be} + {{W{1'b0}}, c0};
        nocin = {1'b0, ta} + {1'b0, be};
        s     = int'($signed(ta)) + int'($signed(be)) + (c0 ? 1 : 0);
        m_ovf = (s > 32767) || (s < -32768);
        return {full[W-1:0], full[W], m_ovf, (full[W-1:0] == '0), ((ta ^ be) == '1), nocin[W]};
    endfunction

    task automatic push(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tcin, input logic tsub);
        sb_t e;
        e.v   = model(ta, tb, tcin, tsub);
        e.acc = cyc;
        e.lat = lat_chk;
        sbq.push_back(e);
    endtask

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tcin, input logic tsub);
        bit done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            a        = ta;
            b        = tb;
            cin      = tcin;
            sub      = tsub;
            in_valid = 1'b1;
            #1;
            if (in_ready) begin
                push(ta, tb, tcin, tsub);
                done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: a=%h b=%h never accepted within 200 cycles", ta, tb);
        end
    endtask

    task automatic wait_drain(input int maxc);
        for (int n = 0; n < maxc && sbq.size() != 0; n++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results still pending, required 0", sbq.size());
        end
    endtask

    task automatic check_idle(input string tag);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_out_valid: got %b required 0", tag, out_valid);
        end
        checks++;
        if ({sum, cout, ovf, zero, pg, gg} !== '0) begin
            errors++;
            $display("FAIL %s_outputs: got sum=%h cout=%b ovf=%b zero=%b pg=%b gg=%b required all 0",
                     tag, sum, cout, ovf, zero, pg, gg);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_in_ready: got %b required 1", tag, in_ready);
        end
    endtask

    // Random consumer readiness, active only during the sweep.
    initial begin : ready_gen
        forever begin
            @(negedge clk);
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compares transfers against the scoreboard, checks stall behaviour.
    initial begin : monitor
        logic [W+4:0] cur;
        logic [W+4:0] held;
        bit           held_v;
        sb_t          e;
        held_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                held_v = 1'b0;
            end else begin
                cur = {sum, cout, ovf, zero, pg, gg};
                if (held_v) begin
                    checks++;
                    if (out_valid !== 1'b1 || cur !== held) begin
                        errors++;
                        $display("FAIL hold: got valid=%b val=%h required valid=1 val=%h", out_valid, cur, held);
                    end
                end
                if (out_valid && out_ready) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got val=%h with no op outstanding", cur);
                    end else begin
                        e = sbq.pop_front();
                        checks++;
                        if (cur !== e.v) begin
                            errors++;
                            $display("FAIL result: got sum=%h c/o/z/pg/gg=%b required sum=%h c/o/z/pg/gg=%b",
                                     cur[W+4:5], cur[4:0], e.v[W+4:5], e.v[4:0]);
                        end
                        if (e.lat) begin
                            checks++;
                            if (cyc - e.acc != ST) begin
                                errors++;
                                $display("FAIL latency: got %0d cycles required %0d", cyc - e.acc, ST);
                            end
                        end
                    end
                end
                if (out_valid && !out_ready) begin
                    checks++;
                    if (in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_in_ready: got %b required 0", in_ready);
                    end
                    held_v = 1'b1;
                    held   = cur;
                end else begin
                    held_v = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit (checks=%0d errors=%0d)", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [W-1:0] fa;
        logic [W-1:0] fb;
        logic [W-1:0] bpa [8];
        logic [W-1:0] bpb [8];
        int           n;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle("reset");

        // Directed corners.
        lat_chk = 1'b1;
        issue(16'h0000, 16'hffff, 1'b0, 1'b0);
        issue(16'h0000, 16'hffff, 1'b1, 1'b0);
        issue(16'hffff, 16'hffff, 1'b1, 1'b0);
        issue(16'h0005, 16'h0007, 1'b0, 1'b1);
        issue(16'h7fff, 16'h0001, 1'b0, 1'b0);
        issue(16'h8000, 16'h0001, 1'b0, 1'b1);
        issue(16'h00ff, 16'h0001, 1'b0, 1'b0);
        wait_drain(50);

        // Backpressure: back-to-back ops, consumer stalls in cycles 3..5.
        lat_chk = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bpa[i] = W'($urandom);
            bpb[i] = W'($urandom);
        end
        n = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            out_ready = !(i >= 3 && i <= 5);
            if (n < 8) begin
                a        = bpa[n];
                b        = bpb[n];
                cin      = 1'b0;
                sub      = n[0];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready) begin
                push(bpa[n], bpb[n], 1'b0, n[0]);
                n++;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL bp_accepted: got %0d ops accepted required 8", n);
        end
        wait_drain(50);

        // Reset with two ops in flight; they must never emerge.
        out_ready = 1'b0;
        issue(16'h1234, 16'h1111, 1'b0, 1'b0);
        issue(16'h4321, 16'h0101, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        sbq.delete();
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        check_idle("midreset");
        lat_chk = 1'b1;
        issue(16'h0f0f, 16'h00f1, 1'b0, 1'b0);
        wait_drain(50);

        // Fibonacci stream.
        fa = '0;
        fb = 16'd1;
        while (fa < 16'd1024) begin
            issue(fa, fb, 1'b0, 1'b0);
            fa = fa + fb;
            fb = fb + fa;
        end
        wait_drain(50);

        // Random sweep with random consumer readiness and input gaps.
        lat_chk    = 1'b0;
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        wait_drain(500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
